// File: rtl/alu_opb_stage_if.sv
// Handshake and operand bus between the register file / immediate extractor
// and the registered ALU operand-B stage.
interface alu_opb_stage_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_srcb;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] r2_dout;
  logic              b_we;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_opb;
  logic              sel_err;

  // Upstream/consumer side: drives operands and the ALU's ready.
  modport master (
    output in_valid, alu_srcb, imm, r2_dout, b_we, out_ready,
    input  in_ready, out_valid, alu_opb, sel_err
  );

  // Stage side.
  modport slave (
    input  in_valid, alu_srcb, imm, r2_dout, b_we, out_ready,
    output in_ready, out_valid, alu_opb, sel_err
  );
endinterface

// File: rtl/alu_opb_stage.sv
// Registered ALU operand-B select: owns the architectural B latch, muxes seven
// operand sources and presents the result through a one-entry valid/ready register.
module alu_opb_stage #(
  parameter int          DATA_W   = 32,
  parameter int          IMM_W    = 16,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned BR_SHIFT = 2
) (
  input logic          clk,
  input logic          rst,
  alu_opb_stage_if.slave bus
);

  typedef enum logic [2:0] {
    SRC_B_LATCH = 3'b000,
    SRC_PC_INC  = 3'b001,
    SRC_SEXT    = 3'b010,
    SRC_BRANCH  = 3'b011,
    SRC_ZEXT    = 3'b100,
    SRC_UPPER   = 3'b101,
    SRC_BYPASS  = 3'b110,
    SRC_RSVD    = 3'b111
  } src_e;

  generate
    if (DATA_W < IMM_W) begin : g_bad_width
      $error("alu_opb_stage: DATA_W must be >= IMM_W");
    end
  endgenerate

  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;

  logic signed [IMM_W-1:0] imm_s;
  logic [DATA_W-1:0]       sext_imm;
  logic [DATA_W-1:0]       zext_imm;
  logic [DATA_W-1:0]       b_eff;
  logic [DATA_W-1:0]       sel_val;
  logic                    sel_flag;
  logic                    in_ready;
  logic                    accept;

  // The only combinational output path: out_ready -> in_ready.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign imm_s    = bus.imm;
  assign sext_imm = DATA_W'(imm_s);
  assign zext_imm = DATA_W'(bus.imm);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    b_d      = bus.b_we ? bus.r2_dout : b_q;
    // A same-cycle B load is forwarded to a select-000 accept (write-through).
    b_eff    = b_d;
    sel_val  = '0;
    sel_flag = 1'b0;
    case (src_e'(bus.alu_srcb))
      SRC_B_LATCH: sel_val = b_eff;
      SRC_PC_INC:  sel_val = DATA_W'(PC_INC);
      SRC_SEXT:    sel_val = sext_imm;
      SRC_BRANCH:  sel_val = sext_imm << BR_SHIFT;
      SRC_ZEXT:    sel_val = zext_imm;
      SRC_UPPER:   sel_val = zext_imm << (DATA_W - IMM_W);
      SRC_BYPASS:  sel_val = bus.r2_dout;
      SRC_RSVD: begin
        sel_val  = '0;
        sel_flag = 1'b1;
      end
      default: begin
        sel_val  = '0;
        sel_flag = 1'b1;
      end
    endcase

    out_valid_d = out_valid_q;
    opb_d       = opb_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opb_d       = sel_val;
      err_d       = sel_flag;
    end else if (bus.out_ready) begin
      // Consumed with nothing new: operand and flag hold as don't-care.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q         <= '0;
      opb_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      b_q         <= b_d;
      opb_q       <= opb_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_opb   = opb_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_alu_opb_stage.sv
// Self-checking bench for alu_opb_stage: directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_alu_opb_stage;

  localparam int DW = 32;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_opb_stage_if #(.DATA_W(DW), .IMM_W(IW)) bus ();
  alu_opb_stage_if #(.DATA_W(16), .IMM_W(16)) cbus ();

  alu_opb_stage #(.DATA_W(DW), .IMM_W(IW), .PC_INC(4), .BR_SHIFT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_opb_stage #(.DATA_W(16), .IMM_W(16), .PC_INC(4), .BR_SHIFT(1)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (cbus)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Operand value from the source rules, using plain 64-bit arithmetic.
  function automatic longint unsigned expect_opb(input int sel, input longint unsigned imm_v,
                                                 input longint unsigned b_v, input longint unsigned r2_v,
                                                 input int dw, input int iw, input int pc_inc, input int brs);
    longint unsigned mask;
    longint          simm;
    mask = (64'd1 << dw) - 64'd1;
    simm = (imm_v >= (64'd1 << (iw - 1))) ? longint'(imm_v) - longint'(64'd1 << iw) : longint'(imm_v);
    case (sel)
      0:       return b_v & mask;
      1:       return longint'(pc_inc) & mask;
      2:       return longint'(simm) & mask;
      3:       return longint'(simm * (longint'(1) << brs)) & mask;
      4:       return imm_v & mask;
      5:       return (imm_v * (64'd1 << (dw - iw))) & mask;
      6:       return r2_v & mask;
      default: return 64'd0;
    endcase
  endfunction

  // Model state for the 32-bit instance: one held operand plus the B latch.
  bit              m_on = 0;
  bit              m_valid;
  longint unsigned m_opb;
  bit              m_err;
  longint unsigned m_b;

  always @(negedge clk) begin
    if (m_on) begin
      check("cmp_out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("cmp_in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
      if (m_valid) begin
        check("cmp_alu_opb", 64'(bus.alu_opb), m_opb);
        check("cmp_sel_err", 64'(bus.sel_err), 64'(m_err));
      end
    end
    if (rst) begin
      m_on = 1; m_valid = 0; m_opb = 0; m_err = 0; m_b = 0;
    end else if (m_on) begin
      longint unsigned b_next;
      b_next = bus.b_we ? 64'(bus.r2_dout) : m_b;
      if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_opb   = expect_opb(int'(bus.alu_srcb), 64'(bus.imm), b_next, 64'(bus.r2_dout), DW, IW, 4, 2);
        m_err   = (bus.alu_srcb == 3'b111);
        m_valid = 1;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
      m_b = b_next;
    end
  end

  // Drive one cycle's inputs after the edge, then advance to just past the next edge.
  task automatic step(input bit v, input logic [2:0] sel, input logic [15:0] imm_v,
                      input logic [31:0] r2_v, input bit we);
    bus.in_valid = v;
    bus.alu_srcb = sel;
    bus.imm      = imm_v;
    bus.r2_dout  = r2_v;
    bus.b_we     = we;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_exp [1:7];

  initial begin
    sweep_exp[1] = 32'h0000_0004;
    sweep_exp[2] = 32'hFFFF_8004;
    sweep_exp[3] = 32'hFFFE_0010;
    sweep_exp[4] = 32'h0000_8004;
    sweep_exp[5] = 32'h8004_0000;
    sweep_exp[6] = 32'h1234_5678;
    sweep_exp[7] = 32'h0000_0000;

    cbus.in_valid = 0; cbus.alu_srcb = 0; cbus.imm = 0; cbus.r2_dout = 0;
    cbus.b_we = 0; cbus.out_ready = 1;
    bus.out_ready = 1;

    // Reset held with activity on the inputs.
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b000, 16'h0, 32'hDEAD_BEEF, 1'b1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_alu_opb", 64'(bus.alu_opb), 64'd0);
      check("rst_sel_err", 64'(bus.sel_err), 64'd0);
    end
    rst = 0;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    step(1'b1, 3'b000, 16'h0, 32'hDEAD_BEEF, 1'b0);
    check("rst_b_latch", 64'(bus.alu_opb), 64'h0);
    check("rst_b_latch_valid", 64'(bus.out_valid), 64'd1);

    // Source sweep.
    for (int s = 1; s <= 7; s++) begin
      step(1'b1, 3'(s), 16'h8004, 32'h1234_5678, 1'b0);
      check($sformatf("sweep_sel%0d", s), 64'(bus.alu_opb), 64'(sweep_exp[s]));
      check($sformatf("sweep_err%0d", s), 64'(bus.sel_err), 64'(s == 7));
    end

    // B latch load, then use on a later cycle, then write-through.
    step(1'b0, 3'b000, 16'h0, 32'hA5A5_A5A5, 1'b1);
    step(1'b1, 3'b000, 16'h0, 32'h0000_0001, 1'b0);
    check("b_latch_held", 64'(bus.alu_opb), 64'hA5A5_A5A5);
    step(1'b1, 3'b000, 16'h0, 32'h0000_0077, 1'b1);
    check("b_write_through", 64'(bus.alu_opb), 64'h77);

    // Backpressure.
    step(1'b1, 3'b010, 16'h0001, 32'h0, 1'b0);
    check("bp_loaded", 64'(bus.alu_opb), 64'h1);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      step(1'b1, 3'(i + 4), 16'h7000 + 16'(i), 32'hBAD0_0000 + 32'(i), 1'b0);
      check("bp_opb_hold", 64'(bus.alu_opb), 64'h1);
      check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    step(1'b1, 3'b110, 16'h0, 32'h0000_CAFE, 1'b0);
    check("bp_next_load", 64'(bus.alu_opb), 64'hCAFE);

    // Back-to-back full throughput.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'b110, 16'h0, 32'h100 + 32'(i), 1'b0);
      check($sformatf("b2b_opb%0d", i), 64'(bus.alu_opb), 64'h100 + 64'(i));
      check($sformatf("b2b_valid%0d", i), 64'(bus.out_valid), 64'd1);
    end
    step(1'b0, 3'b000, 16'h0, 32'h0, 1'b0);
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Parameter corner: DATA_W=IMM_W=16, BR_SHIFT=1.
    cbus.in_valid = 1; cbus.alu_srcb = 3'b101; cbus.imm = 16'hBEEF;
    @(posedge clk); #1;
    check("corner_upper", 64'(cbus.alu_opb), 64'hBEEF);
    check("corner_upper_model", 64'(cbus.alu_opb), expect_opb(5, 64'hBEEF, 0, 0, 16, 16, 4, 1));
    cbus.alu_srcb = 3'b011; cbus.imm = 16'hC000;
    @(posedge clk); #1;
    check("corner_branch", 64'(cbus.alu_opb), 64'h8000);
    check("corner_branch_model", 64'(cbus.alu_opb), expect_opb(3, 64'hC000, 0, 0, 16, 16, 4, 1));
    cbus.in_valid = 0;

    step(1'b0, 3'b000, 16'h0, 32'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_opb_stage.md
# alu_opb_stage

Parametrised, registered successor to the multicycle CPU's ALU operand-B select. It owns the architectural B latch, picks one of seven operand-B sources, covering register, constant increment, sign/zero-extended immediate, branch-shifted immediate, upper immediate and raw bypass. It presents the result through a one-entry valid/ready output register. It sits between the register file / immediate extractor and the ALU operand-B input.

## Interface
Parameters:
- DATA_W, 32, operand width.
- IMM_W, 16, raw immediate width; DATA_W >= IMM_W required.
- PC_INC, 4, constant presented for the increment source.
- BR_SHIFT, 2, left shift applied to the branch-offset source.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source select and operands are valid this cycle.
- in_ready  out  1  stage can accept this cycle.
- alu_srcb  in  3  source select (encoding below).
- imm  in  IMM_W  raw immediate field.
- r2_dout  in  DATA_W  register-file read port 2.
- b_we  in  1  load B latch from r2_dout (independent of in_valid).
- out_valid  out  1  alu_opb holds an unconsumed operand.
- out_ready  in  1  ALU consumes operand this cycle.
- alu_opb  out  DATA_W  registered operand B.
- sel_err  out  1  registered; set alongside out_valid when the held operand came from a reserved select.

## Operation
- Source encoding (sext = sign-extend imm to DATA_W, zext = zero-extend):
  - 000: B latch.
  - 001: PC_INC, zero-extended to DATA_W.
  - 010: sext(imm).
  - 011: sext(imm) << BR_SHIFT; bits shifted past DATA_W are discarded.
  - 100: zext(imm).
  - 101: imm << (DATA_W-IMM_W), low bits 0 (upper-immediate).
  - 110: r2_dout directly (bypass B latch).
  - 111: reserved. Operand is 0 and sel_err=1.
- B latch: DATA_W register. On b_we it loads r2_dout, otherwise it holds. It is not gated by in_ready.
- Write-through: if b_we and an accepted select 000 occur in the same cycle, the registered operand is the new r2_dout, not the old latch.
- Accept: `accept = in_valid && in_ready`. `in_ready = !out_valid || out_ready` is combinational, with no dependence on in_valid.
- Output register:
  - On accept: alu_opb and sel_err load the selected value and flag, and out_valid goes to 1.
  - On out_ready && out_valid without accept: out_valid goes to 0. alu_opb and sel_err hold their last values (don't-care).
  - When out_valid=1 and out_ready=0: alu_opb, sel_err and out_valid hold. Input is stalled (in_ready=0).
  - Simultaneous consume and accept: new operand is loaded and out_valid stays 1. Full throughput is one operand per cycle.
- Inputs other than b_we/r2_dout are ignored when accept=0.

## Timing
- Reset (rst=1 at an edge): out_valid=0, alu_opb=0, sel_err=0, B latch=0. in_ready reads 1 in the cycle after reset.
- Reset wins over accept, b_we and consume in the same cycle. An operand held at reset is discarded.
- Latency: operand accepted at edge N is visible on alu_opb with out_valid=1 after edge N, i.e. 1 cycle.
- B latch update from b_we at edge N is usable by a select-000 accept at edge N+1 or later. A same-edge accept uses write-through, as above.
- No combinational path from alu_srcb/imm/r2_dout to alu_opb. The only combinational output path is out_ready -> in_ready.

## Test plan
- Reset/idle: assert rst 2 cycles with in_valid=1, b_we=1, r2_dout=0xDEADBEEF. Require out_valid=0, alu_opb=0, sel_err=0. Then select 000 with b_we=0 yields 0x00000000.
- Source sweep (defaults), out_ready=1, imm=0x8004, r2_dout=0x12345678. Required alu_opb per select:
  - 001 -> 0x00000004
  - 010 -> 0xFFFF8004
  - 011 -> 0xFFFE0010
  - 100 -> 0x00008004
  - 101 -> 0x80040000
  - 110 -> 0x12345678
  - 111 -> 0x00000000 with sel_err=1
- B latch: b_we with r2_dout=0xA5A5A5A5, then r2_dout changes to 0x1. Select 000 next cycle -> 0xA5A5A5A5. Same-cycle b_we=1, r2_dout=0x77, select 000 -> 0x00000077.
- Backpressure: accept imm=0x0001 (sel 010), hold out_ready=0 for 3 cycles while changing inputs. Require alu_opb=0x00000001, out_valid=1 and in_ready=0 throughout. Release out_ready -> in_ready=1 in the same cycle, and the next operand loads.
- Back-to-back: 8 consecutive accepts with out_ready=1 -> 8 consecutive out_valid cycles, each operand exactly once, in order.
- Parameter corner: DATA_W=16, IMM_W=16, BR_SHIFT=1.
  - Select 101 with imm=0xBEEF -> 0xBEEF.
  - Select 011 with imm=0xC000 -> 0x8000, top bit discarded.
